pu_accum: RTL and testbench

Accumulator processing unit that sits directly downstream of pu_mult on the NITTA data bus and consumes the products it emits. It sums a stream of signed operands into one running value (multiply-accumulate chain) and returns the sum on request. It propagates the invalid attribute and reports overflow. Its bus port protocol is the same as the multiplier's (wr/oe strobes, data plus attribute words).

---
 rtl/nitta_pu_pkg.sv | 16 +
 rtl/pu_accum_add.sv | 53 +++++
 rtl/pu_accum.sv | 127 ++++++++++++
 tb/tb_pu_accum.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nitta_pu_pkg.sv
// nitta_pu_pkg
//   Constants shared by the NITTA processing units (pu_mult, pu_accum) so that
//   producers and consumers on the data bus agree on the attribute word layout
//   and the default datapath widths.
//   No ports (package).
package nitta_pu_pkg;

  // Default widths of the bus data word and attribute word.
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ATTR_WIDTH = 4;

  // Bit positions inside an attribute word.
  localparam int ATTR_INVALID  = 0;
  localparam int ATTR_OVERFLOW = 1;

endpackage

// File: rtl/pu_accum_add.sv
// pu_accum_add
//   Combinational adder for the accumulator: adds a DATA_WIDTH base value and a
//   DATA_WIDTH+1 operand (wide enough to hold a negated minimum), detects
//   whether the exact sum leaves the DATA_WIDTH range, and produces the value
//   to commit.
//   Build option: PU_ACCUM_SATURATE_EN defined -> out-of-range sums clamp to
//   the nearest representable extreme; undefined -> two's complement wrap.
// Ports:
//   base    in   DATA_WIDTH    current accumulator (or 0 on init)
//   op      in   DATA_WIDTH+1  signed operand, already negated if needed
//   result  out  DATA_WIDTH    value to commit into the accumulator
//   ovf     out  1             exact sum did not fit in DATA_WIDTH
module pu_accum_add
  import nitta_pu_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic signed [DATA_WIDTH-1:0] base,
  input  logic signed [DATA_WIDTH:0]   op,
  output logic signed [DATA_WIDTH-1:0] result,
  output logic                         ovf
);

  localparam int SUM_W = DATA_WIDTH + 2;

  logic signed [SUM_W-1:0] sum;
  logic                    fits;

  // Clamp or wrap a sum that is known not to fit.
  function automatic logic signed [DATA_WIDTH-1:0] limit(input logic signed [SUM_W-1:0] s);
    logic signed [DATA_WIDTH-1:0] r;
`ifdef PU_ACCUM_SATURATE_EN
    if (s[SUM_W-1]) begin
      r = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      r = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
`else
    r = s[DATA_WIDTH-1:0];
`endif
    return r;
  endfunction

  // Both addends sign-extended to the full sum width; this can never
  // overflow itself, so the top bits tell us exactly whether the result fits.
  assign sum = {{2{base[DATA_WIDTH-1]}}, base} + {op[DATA_WIDTH], op};

  // In range iff the top three bits are all copies of the sign.
  assign fits   = (sum[SUM_W-1:DATA_WIDTH-1] == {3{sum[SUM_W-1]}});
  assign ovf    = ~fits;
  assign result = fits ? sum[DATA_WIDTH-1:0] : limit(sum);

endmodule

// File: rtl/pu_accum.sv
// pu_accum
//   Accumulator processing unit on the NITTA data bus. Sums a stream of signed
//   operands (typically products from pu_mult) into one running value and
//   returns it on request, together with sticky invalid/overflow flags.
//   Two-stage write pipeline: stage 1 captures (and optionally negates) the
//   operand, stage 2 commits it into the accumulator. Writes may arrive every
//   cycle. A read returns the value committed before the read edge.
//   Build option: PU_ACCUM_SATURATE_EN (see pu_accum_add) selects clamping
//   instead of wrapping on overflow; the overflow flag is the same either way.
// Ports:
//   clk          in   1           clock, rising edge
//   rst          in   1           asynchronous reset, active low
//   signal_wr    in   1           operand write strobe
//   signal_init  in   1           with signal_wr: start a new sum
//   signal_neg   in   1           with signal_wr: subtract the operand
//   signal_oe    in   1           read strobe
//   data_in      in   DATA_WIDTH  operand
//   attr_in      in   ATTR_WIDTH  operand attributes
//   data_out     out  DATA_WIDTH  accumulated value, 0 when not reading
//   attr_out     out  ATTR_WIDTH  accumulated flags, 0 when not reading
module pu_accum
  import nitta_pu_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ATTR_WIDTH = DEF_ATTR_WIDTH,
  parameter int INVALID    = ATTR_INVALID,
  parameter int OVERFLOW   = ATTR_OVERFLOW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signal_wr,
  input  logic                  signal_init,
  input  logic                  signal_neg,
  input  logic                  signal_oe,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ATTR_WIDTH-1:0] attr_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [ATTR_WIDTH-1:0] attr_out
);

  // Stage 1 registers
  logic                         vld_p1;
  logic                         init_p1;
  logic                         inv_p1;
  logic signed [DATA_WIDTH:0]   op_p1;

  // Stage 2 (committed) state
  logic signed [DATA_WIDTH-1:0] acc_p2;
  logic                         inv_sticky_p2;
  logic                         ovf_sticky_p2;

  logic signed [DATA_WIDTH:0]   op_ext;
  logic signed [DATA_WIDTH-1:0] add_base;
  logic signed [DATA_WIDTH-1:0] add_result;
  logic                         add_ovf;
  logic [ATTR_WIDTH-1:0]        flags;
  logic                         unused_attr;

  // Only the invalid bit of the incoming attributes matters here.
  assign unused_attr = ^attr_in;

  // One extra bit so that negating the most negative value stays exact.
  assign op_ext = {data_in[DATA_WIDTH-1], data_in};

  // ---- stage 0 -> 1: capture operand ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1  <= 1'b0;
      init_p1 <= 1'b0;
      inv_p1  <= 1'b0;
      op_p1   <= '0;
    end else begin
      vld_p1 <= signal_wr;
      if (signal_wr) begin
        init_p1 <= signal_init;
        inv_p1  <= attr_in[INVALID];
        op_p1   <= signal_neg ? -op_ext : op_ext;
      end
    end
  end

  // init discards the previous sum by adding onto zero instead.
  assign add_base = init_p1 ? '0 : acc_p2;

  pu_accum_add #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_add (
    .base  (add_base),
    .op    (op_p1),
    .result(add_result),
    .ovf   (add_ovf)
  );

  // ---- stage 1 -> 2: commit into accumulator ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_p2        <= '0;
      inv_sticky_p2 <= 1'b0;
      ovf_sticky_p2 <= 1'b0;
    end else if (vld_p1) begin
      acc_p2        <= add_result;
      inv_sticky_p2 <= (init_p1 ? 1'b0 : inv_sticky_p2) | inv_p1;
      ovf_sticky_p2 <= (init_p1 ? 1'b0 : ovf_sticky_p2) | add_ovf;
    end
  end

  always_comb begin
    flags           = '0;
    flags[INVALID]  = inv_sticky_p2;
    flags[OVERFLOW] = ovf_sticky_p2;
  end

  // ---- read port: registered, zero when not reading ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out <= '0;
      attr_out <= '0;
    end else if (signal_oe) begin
      data_out <= acc_p2;
      attr_out <= flags;
    end else begin
      data_out <= '0;
      attr_out <= '0;
    end
  end

endmodule

// File: tb/tb_pu_accum.sv
// tb_pu_accum
//   Scoreboard bench for pu_accum: each read request pushes its hand-computed
//   expected value; a monitor pops and compares whenever the DUT presents a
//   read result, and otherwise requires the idle outputs to be zero.
//   Works with and without PU_ACCUM_SATURATE_EN.
module tb_pu_accum;

  logic        clk;
  logic        rst;
  logic        signal_wr;
  logic        signal_init;
  logic        signal_neg;
  logic        signal_oe;
  logic [31:0] data_in;
  logic [3:0]  attr_in;
  logic [31:0] data_out;
  logic [3:0]  attr_out;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  a;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  logic oe_q;

`ifdef PU_ACCUM_SATURATE_EN
  localparam logic [31:0] POS_OVF = 32'h7FFF_FFFF;
  localparam logic [31:0] NEG_OVF = 32'h8000_0000;
  localparam logic [31:0] BIG_OVF = 32'h8000_0010;
`else
  localparam logic [31:0] POS_OVF = 32'h8000_0000;
  localparam logic [31:0] NEG_OVF = 32'h7FFF_FFFF;
  localparam logic [31:0] BIG_OVF = 32'h8000_0010;
`endif

  pu_accum dut (
    .clk        (clk),
    .rst        (rst),
    .signal_wr  (signal_wr),
    .signal_init(signal_init),
    .signal_neg (signal_neg),
    .signal_oe  (signal_oe),
    .data_in    (data_in),
    .attr_in    (attr_in),
    .data_out   (data_out),
    .attr_out   (attr_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tracks whether the DUT sampled oe at the last edge (output valid now).
  always @(posedge clk or negedge rst) begin
    if (!rst) oe_q <= 1'b0;
    else      oe_q <= signal_oe;
  end

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (oe_q) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_read: data_out=%h with no pending expectation", data_out);
      end else begin
        e = exp_q.pop_front();
        n_chk++;
        if (data_out !== e.d) begin
          n_fail++;
          $display("FAIL read_data @%0t: got %h expected %h", $time, data_out, e.d);
        end
        n_chk++;
        if (attr_out !== e.a) begin
          n_fail++;
          $display("FAIL read_attr @%0t: got %h expected %h", $time, attr_out, e.a);
        end
      end
    end else begin
      n_chk++;
      if (data_out !== 32'h0 || attr_out !== 4'h0) begin
        n_fail++;
        $display("FAIL idle_zero @%0t: data_out=%h attr_out=%h expected 0/0", $time, data_out, attr_out);
      end
    end
  end

  // One clock edge with the given inputs applied.
  task automatic cyc(input logic wr, input logic init, input logic neg, input logic oe,
                     input logic [31:0] d, input logic [3:0] a);
    signal_wr   = wr;
    signal_init = init;
    signal_neg  = neg;
    signal_oe   = oe;
    data_in     = d;
    attr_in     = a;
    @(posedge clk);
    #1;
    signal_wr   = 1'b0;
    signal_init = 1'b0;
    signal_neg  = 1'b0;
    signal_oe   = 1'b0;
  endtask

  task automatic wr(input logic init, input logic neg, input logic [31:0] d, input logic [3:0] a);
    cyc(1'b1, init, neg, 1'b0, d, a);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0);
  endtask

  task automatic rd(input logic [31:0] ed, input logic [3:0] ea);
    exp_q.push_back('{d: ed, a: ea});
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 4'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst         = 1'b0;
    signal_wr   = 1'b0;
    signal_init = 1'b0;
    signal_neg  = 1'b0;
    signal_oe   = 1'b0;
    data_in     = '0;
    attr_in     = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    idle();

    // Nothing written yet: reads give the cleared accumulator.
    rd(32'h0, 4'h0);

    // Basic sum
    wr(1, 0, 32'd5, 4'h0);
    wr(0, 0, 32'd7, 4'h0);
    idle(); idle();
    rd(32'd12, 4'h0);

    // Subtract, then subtract a negative
    wr(1, 0, 32'd4, 4'h0);
    wr(0, 1, 32'd5, 4'h0);
    idle();
    rd(32'hFFFF_FFFF, 4'h0);
    wr(0, 1, 32'hFFFF_FFF6, 4'h0);
    idle();
    rd(32'd9, 4'h0);

    // Positive overflow, then init clears the sticky flag
    wr(1, 0, 32'h7FFF_FFF0, 4'h0);
    wr(0, 0, 32'h0000_0020, 4'h0);
    idle();
`ifdef PU_ACCUM_SATURATE_EN
    rd(32'h7FFF_FFFF, 4'h2);
`else
    rd(BIG_OVF, 4'h2);
`endif
    wr(1, 0, 32'd3, 4'h0);
    idle();
    rd(32'd3, 4'h0);

    // Negative overflow: MIN - 1
    wr(1, 0, 32'h8000_0000, 4'h0);
    wr(0, 1, 32'd1, 4'h0);
    idle();
    rd(NEG_OVF, 4'h2);

    // Negating MIN alone: +2^31 does not fit
    wr(1, 1, 32'h8000_0000, 4'h0);
    idle();
    rd(POS_OVF, 4'h2);

    // Invalid propagation
    wr(1, 0, 32'd4, 4'h1);
    wr(0, 0, 32'd5, 4'h0);
    idle();
    rd(32'd9, 4'h1);
    wr(1, 0, 32'd1, 4'h0);
    idle();
    rd(32'd1, 4'h0);

    // Back-to-back writes with an early (stale) read
    wr(1, 0, 32'd1, 4'h0);
    wr(0, 0, 32'd2, 4'h0);
    wr(0, 0, 32'd3, 4'h0);
    rd(32'd3, 4'h0);
    idle();
    rd(32'd6, 4'h0);

    // Simultaneous write and read returns the pre-write value
    exp_q.push_back('{d: 32'd6, a: 4'h0});
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 32'd10, 4'h0);
    idle();
    // Held oe re-reads every cycle
    exp_q.push_back('{d: 32'd10, a: 4'h0});
    exp_q.push_back('{d: 32'd10, a: 4'h0});
    signal_oe = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    signal_oe = 1'b0;
    // init/neg without wr must not disturb the sum
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'd77, 4'h1);
    idle();
    rd(32'd10, 4'h0);

    // Reset while an operand is in flight; outputs clear immediately
    rd(32'd10, 4'h0);
    wr(1, 0, 32'd8, 4'h0);
    rst = 1'b0;
    #2;
    n_chk++;
    if (data_out !== 32'h0 || attr_out !== 4'h0) begin
      n_fail++;
      $display("FAIL async_reset: data_out=%h attr_out=%h expected 0/0", data_out, attr_out);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle();
    rd(32'h0, 4'h0);
    wr(0, 0, 32'd2, 4'h0);
    idle();
    rd(32'd2, 4'h0);

    idle(); idle();
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_reads: %0d left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
